uart_tx_sched: RTL

- Round-robin scheduler that shares one uart_tx transmitter between NREQ byte producers. Examples: CPU port, DMA, debug console.
- Accepts bytes on per-requester valid/ready handshakes and drives the transmitter's active-low wrn strobe and d_in.
- Paces writes using t_empty.
- Supports packet lock: a granted requester keeps the transmitter until it presents a byte with last=1.

---
 rtl/uart_tx_sched_pkg.sv | 12 +
 rtl/uart_tx_sched_if.sv | 23 ++
 rtl/uart_tx_sched_rr_pick.sv | 28 ++
 rtl/uart_tx_sched.sv | 124 ++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx request scheduler.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STROBE     = 2'd1,
    ST_WAIT_ACK   = 2'd2,
    ST_WAIT_EMPTY = 2'd3
  } state_e;
endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshakes plus the uart_tx write-side signals of the scheduler.
interface uart_tx_sched_if import uart_pkg::*; #(parameter int NREQ = 4);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][BYTE_W-1:0] req_data;
  logic [NREQ-1:0]             req_last;
  logic [NREQ-1:0]             req_ready;
  logic                        wrn;
  logic [BYTE_W-1:0]           d_in;
  logic                        t_empty;
  logic [IDX_W-1:0]            grant_id;
  logic                        busy;
  logic                        timeout_err;

  modport master (
    output req_valid, req_data, req_last, t_empty,
    input  req_ready, wrn, d_in, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, t_empty,
    output req_ready, wrn, d_in, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin search: first valid requester at or after i_ptr.
module rr_pick import uart_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_sel,
  output logic             o_found
);
  int w_dist;
  int w_best;

  // Smallest rotational distance from the pointer wins; avoids variable indexing.
  always_comb begin
    o_sel   = '0;
    o_found = 1'b0;
    w_best  = NREQ;
    w_dist  = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NREQ - int'(i_ptr));
      if (i_valid[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_sel   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between NREQ byte producers: round-robin grant, packet
// lock, one-cycle wrn strobe and t_empty pacing with a sticky ack timeout.
module uart_tx_sched import uart_pkg::*; #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 64
) (
  input logic            clk16x,
  input logic            clr,
  uart_tx_sched_if.slave bus
);
  localparam int TW = $clog2(TO_CYCLES + 1);

  state_e              r_state, w_state_nx;
  logic                r_wrn, r_busy, r_lock, r_terr;
  logic [BYTE_W-1:0]   r_d_in;
  logic [NREQ-1:0]     r_ready;
  logic [IDX_W-1:0]    r_grant, r_rr_ptr;
  logic [TW-1:0]       r_timer;

  logic [7:0]          w_vpad, w_lpad;
  logic [7:0][7:0]     w_dpad;
  logic [IDX_W-1:0]    w_rr_sel, w_sel, w_ptr_nx;
  logic                w_found, w_go, w_to;
  logic                w_grant, w_strobe, w_ack_to, w_release;

  // Pad requester vectors to 8 entries so a 3-bit index always fits.
  always_comb begin
    w_vpad = 8'(bus.req_valid);
    w_lpad = 8'(bus.req_last);
    w_dpad = '0;
    for (int i = 0; i < NREQ; i++) w_dpad[i] = bus.req_data[i];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_sel   (w_rr_sel),
    .o_found (w_found)
  );

  assign w_sel    = r_lock ? r_grant : w_rr_sel;
  assign w_go     = bus.t_empty && (r_lock ? w_vpad[r_grant] : w_found);
  assign w_to     = (r_timer == TW'(TO_CYCLES - 1));
  assign w_ptr_nx = (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:       if (w_go) w_state_nx = ST_STROBE;
      ST_STROBE:     w_state_nx = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!bus.t_empty) w_state_nx = ST_WAIT_EMPTY;
        else if (w_to)    w_state_nx = ST_IDLE;
      end
      ST_WAIT_EMPTY: if (bus.t_empty) w_state_nx = ST_IDLE;
      default:       w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant   = 1'b0;
    w_strobe  = 1'b0;
    w_ack_to  = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ST_IDLE:       w_grant   = w_go;
      ST_STROBE:     w_strobe  = 1'b1;
      ST_WAIT_ACK:   w_ack_to  = bus.t_empty && w_to;
      ST_WAIT_EMPTY: w_release = bus.t_empty && !r_lock;
      default:       ;
    endcase
  end

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      r_wrn    <= 1'b1;
      r_d_in   <= '0;
      r_ready  <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_terr   <= 1'b0;
      r_rr_ptr <= '0;
      r_lock   <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_ready <= '0;
      if (w_grant) begin
        r_d_in  <= w_dpad[w_sel];
        r_ready <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
        r_grant <= w_sel;
        r_busy  <= 1'b1;
        r_lock  <= ~w_lpad[w_sel];
        r_wrn   <= 1'b0;
      end
      if (w_strobe) begin
        r_wrn   <= 1'b1;
        r_timer <= '0;
      end
      if ((r_state == ST_WAIT_ACK) && (r_timer != '1)) r_timer <= r_timer + 1'b1;
      // A lost ack abandons the packet so other requesters are not starved.
      if (w_ack_to) begin
        r_terr <= 1'b1;
        r_lock <= 1'b0;
        r_busy <= 1'b0;
      end
      if (w_release) begin
        r_rr_ptr <= w_ptr_nx;
        r_busy   <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = r_ready;
  assign bus.wrn         = r_wrn;
  assign bus.d_in        = r_d_in;
  assign bus.grant_id    = r_grant;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_terr;
endmodule
